sh_ext_slave: RTL and testbench
===============================

SH_EXT_SLAVE -- requirements
Module: sh_ext_slave

Interface
REQ-001 SHALL have parameter CS_NUM, default 0: chip-select area (0..3) this responder serves.
REQ-002 SHALL have parameter PORT_SZ, default 2'b11: port width, 01=8-bit, 10=16-bit, 11=32-bit; 00 illegal.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum CLK cycles WAIT_N is held low per access.
REQ-004 Ports (name direction width meaning):
- CLK in 1 system clock
- RST_N in 1 reset, asynchronous, active-low
- CE_R in 1 rising-phase enable, same as the bus master
- CE_F in 1 falling-phase enable
- A in 27 bus address from master
- DO in 32 master write data (lane per PORT_SZ)
- DI out 32 read data to master
- BS_N in 1 bus-cycle start strobe
- CS_N in 1 chip select of area CS_NUM
- RD_WR_N in 1 1=read, 0=write
- RD_N in 1 read strobe
- WE_N in 4 byte write strobes, active low
- WAIT_N out 1 wait request to master, active low
- MEM_A out 27 word address {A[26:2],2'b00}
- MEM_DO out 32 write data, big-endian lane steered
- MEM_BE out 4 byte enables, bit3=[31:24]
- MEM_WE out 1 1=write
- MEM_REQ out 1 request, held until MEM_ACK
- MEM_DI in 32 memory read word
- MEM_ACK in 1 one-cycle completion
- ERR out 1 one-cycle pulse on timeout

Function
REQ-005 SHALL start an access on any CLK edge with CE_R=1, BS_N=0, CS_N=0 while in IDLE or DONE; latch A, RD_WR_N, DO, ~WE_N.
REQ-006 SHALL drive WAIT_N=0 on the clock edge following the start, ensuring it is low by the master's first wait sample (area wait setting W>=01 required; W=00 unsupported).
REQ-007 States: IDLE, REQ (MEM_REQ=1, await MEM_ACK), DONE (WAIT_N=1, hold DI); IDLE->REQ on start; REQ->DONE on MEM_ACK or timeout; DONE->IDLE when CS_N=1 on CE_R; DONE->REQ on a new start.
REQ-008 Lane steering 8-bit: A[1:0]=00/01/10/11 -> MEM_BE 1000/0100/0010/0001; DO[7:0] replicated to all MEM_DO bytes; read returns selected byte on DI[7:0], DI[31:8]=0.
REQ-009 Lane steering 16-bit: A[1]=0 -> MEM_BE={~WE_N[1:0],2'b00}, A[1]=1 -> {2'b00,~WE_N[1:0]}; read returns selected half on DI[15:0].
REQ-010 32-bit: MEM_BE=~WE_N for writes, 4'b1111 for reads; DI=MEM_DI.
REQ-011 Write with WE_N=4'b1111 at start SHALL still issue MEM_REQ with MEM_BE=0000.
REQ-012 Read data SHALL be registered into DI on MEM_ACK and stable from WAIT_N rising until CS_N=1 or next start.
REQ-013 WAIT_N SHALL rise exactly one CLK after MEM_ACK.
REQ-014 Timeout counter SHALL count CLK cycles in REQ; at TIMEOUT: WAIT_N=1, ERR pulse, DI=32'hFFFFFFFF, MEM_REQ stays until MEM_ACK, whose data is discarded.
REQ-015 Start while a discarded MEM_REQ is outstanding SHALL be delayed (WAIT_N low) until that MEM_ACK.
REQ-016 CS_N rising while in REQ SHALL not cancel MEM_REQ; result dropped, return to IDLE after MEM_ACK.
REQ-017 MEM_ACK outside REQ SHALL be ignored.

Reset
REQ-018 RST_N low: state IDLE, WAIT_N=1, MEM_REQ=0, MEM_WE=0, MEM_BE=0, ERR=0, DI=0, MEM_A=0, MEM_DO=0, counter 0; reset mid-access abandons it without ERR.

Structure
REQ-019 State enum and port-size encodings SHALL reside in the shared CPU package; lane steering SHALL be one sub-module sh_ext_lane (combinational).

Verification
REQ-020 32-bit read A=0x0000104, MEM_ACK after 3 cycles with 0x11223344 -> WAIT_N low 4 cycles, DI=0x11223344, MEM_BE=1111.
REQ-021 8-bit write A[1:0]=10, DO=0x5A, WE_N=1110 -> MEM_BE=0010, MEM_DO=0x5A5A5A5A, MEM_WE=1.
REQ-022 16-bit read A[1]=1, MEM_DI=0xAAAABBBB -> DI=0x0000BBBB.
REQ-023 No MEM_ACK, TIMEOUT=8 -> WAIT_N rises after 8 cycles, ERR one pulse, DI=0xFFFFFFFF.
REQ-024 Back-to-back start in DONE -> second MEM_REQ next cycle, no IDLE gap.
REQ-025 RST_N asserted during REQ -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/sh_ext_pkg.sv
// Shared CPU external-bus definitions: responder state encoding, port-size codes
// and the byte-lane decode helper used by the lane steering logic.
package sh_ext_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DONE = 2'b10
   } sh_state_e;

   localparam logic [1:0] PSZ_8  = 2'b01;
   localparam logic [1:0] PSZ_16 = 2'b10;
   localparam logic [1:0] PSZ_32 = 2'b11;

   // Big-endian byte lane: address offset 0 maps to MEM_BE[3] / data [31:24].
   function automatic logic [3:0] byte_onehot(input logic [1:0] ofs);
      return 4'b1000 >> ofs;
   endfunction

endpackage

// File: rtl/sh_ext_lane.sv
// Combinational byte-lane steering between the CPU bus port width and the
// 32-bit big-endian memory word (write enables, write data, read data).
module sh_ext_lane
   import sh_ext_pkg::*;
(
   input  logic [1:0]  port_sz_i,
   input  logic [1:0]  addr_i,
   input  logic        wr_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wen_i,
   input  logic [31:0] mem_di_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [1:0] half_en_s;

   // Steer enables and data according to the configured port width.
   always_comb begin
      be_o      = 4'b0000;
      wdata_o   = wdata_i;
      rdata_o   = mem_di_i;
      half_en_s = wr_i ? wen_i[1:0] : 2'b11;
      case (port_sz_i)
         PSZ_8: begin
            wdata_o = {4{wdata_i[7:0]}};
            be_o    = byte_onehot(addr_i) & (wr_i ? {4{wen_i[0]}} : 4'b1111);
            case (addr_i)
               2'b00:   rdata_o = {24'h000000, mem_di_i[31:24]};
               2'b01:   rdata_o = {24'h000000, mem_di_i[23:16]};
               2'b10:   rdata_o = {24'h000000, mem_di_i[15:8]};
               default: rdata_o = {24'h000000, mem_di_i[7:0]};
            endcase
         end
         PSZ_16: begin
            wdata_o = {2{wdata_i[15:0]}};
            if (addr_i[1]) begin
               be_o    = {2'b00, half_en_s};
               rdata_o = {16'h0000, mem_di_i[15:0]};
            end else begin
               be_o    = {half_en_s, 2'b00};
               rdata_o = {16'h0000, mem_di_i[31:16]};
            end
         end
         PSZ_32: begin
            be_o = wr_i ? wen_i : 4'b1111;
         end
         default: begin
            be_o = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/sh_ext_slave.sv
// External-bus responder for one chip-select area: turns a CPU bus cycle into a
// held MEM_REQ/MEM_ACK handshake, stretching the master with WAIT_N meanwhile.
module sh_ext_slave
   import sh_ext_pkg::*;
#(
   parameter int unsigned CS_NUM  = 0,
   parameter logic [1:0]  PORT_SZ = 2'b11,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CE_R,
   input  logic        CE_F,
   input  logic [26:0] A,
   input  logic [31:0] DO,
   output logic [31:0] DI,
   input  logic        BS_N,
   input  logic        CS_N,
   input  logic        RD_WR_N,
   input  logic        RD_N,
   input  logic [3:0]  WE_N,
   output logic        WAIT_N,
   output logic [26:0] MEM_A,
   output logic [31:0] MEM_DO,
   output logic [3:0]  MEM_BE,
   output logic        MEM_WE,
   output logic        MEM_REQ,
   input  logic [31:0] MEM_DI,
   input  logic        MEM_ACK,
   output logic        ERR
);

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   sh_state_e   state_q;
   logic [26:0] acc_a_q;
   logic        acc_rd_q;
   logic [31:0] acc_do_q;
   logic [3:0]  acc_en_q;
   logic [15:0] cnt_q;
   logic        orphan_q;
   logic        drop_q;
   logic        wait_n_q;
   logic [26:0] mem_a_q;
   logic [31:0] mem_do_q;
   logic [3:0]  mem_be_q;
   logic        mem_we_q;
   logic        mem_req_q;
   logic [31:0] di_q;
   logic        err_q;

   logic        start_s;
   logic [26:0] iss_a_s;
   logic        iss_rd_s;
   logic [31:0] iss_do_s;
   logic [3:0]  iss_en_s;
   logic [3:0]  lane_be_s;
   logic [31:0] lane_wdata_s;
   logic [31:0] lane_rdata_s;
   logic        unused_s;

   assign start_s  = CE_R & ~BS_N & ~CS_N & ((state_q == ST_IDLE) | (state_q == ST_DONE));
   // A fresh start issues straight from the bus; a delayed issue uses the latched access.
   assign iss_a_s  = start_s ? A : acc_a_q;
   assign iss_rd_s = start_s ? RD_WR_N : acc_rd_q;
   assign iss_do_s = start_s ? DO : acc_do_q;
   assign iss_en_s = start_s ? ~WE_N : acc_en_q;
   assign unused_s = ^{CE_F, RD_N, 2'(CS_NUM)};

   sh_ext_lane u_lane (
      .port_sz_i (PORT_SZ),
      .addr_i    (iss_a_s[1:0]),
      .wr_i      (~iss_rd_s),
      .wdata_i   (iss_do_s),
      .wen_i     (iss_en_s),
      .mem_di_i  (MEM_DI),
      .be_o      (lane_be_s),
      .wdata_o   (lane_wdata_s),
      .rdata_o   (lane_rdata_s)
   );

   // Access state machine with all bus- and memory-side outputs registered.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         acc_a_q   <= 27'd0;
         acc_rd_q  <= 1'b0;
         acc_do_q  <= 32'd0;
         acc_en_q  <= 4'd0;
         cnt_q     <= 16'd0;
         orphan_q  <= 1'b0;
         drop_q    <= 1'b0;
         wait_n_q  <= 1'b1;
         mem_a_q   <= 27'd0;
         mem_do_q  <= 32'd0;
         mem_be_q  <= 4'd0;
         mem_we_q  <= 1'b0;
         mem_req_q <= 1'b0;
         di_q      <= 32'd0;
         err_q     <= 1'b0;
      end else begin
         err_q <= 1'b0;
         // The acknowledge of a timed-out request only retires it; its data is dropped.
         if (orphan_q && MEM_ACK) begin
            orphan_q  <= 1'b0;
            mem_req_q <= 1'b0;
         end
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_s) begin
                  acc_a_q  <= A;
                  acc_rd_q <= RD_WR_N;
                  acc_do_q <= DO;
                  acc_en_q <= ~WE_N;
                  cnt_q    <= 16'd0;
                  drop_q   <= 1'b0;
                  wait_n_q <= 1'b0;
                  state_q  <= ST_REQ;
                  if (!orphan_q) begin
                     mem_a_q   <= {A[26:2], 2'b00};
                     mem_we_q  <= ~RD_WR_N;
                     mem_be_q  <= lane_be_s;
                     mem_do_q  <= lane_wdata_s;
                     mem_req_q <= 1'b1;
                  end
               end else if ((state_q == ST_DONE) && CE_R && CS_N) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_REQ: begin
               if (CE_R && CS_N) begin
                  drop_q <= 1'b1;
               end
               if (orphan_q) begin
                  cnt_q <= 16'd0;
               end else if (!mem_req_q) begin
                  mem_a_q   <= {acc_a_q[26:2], 2'b00};
                  mem_we_q  <= ~acc_rd_q;
                  mem_be_q  <= lane_be_s;
                  mem_do_q  <= lane_wdata_s;
                  mem_req_q <= 1'b1;
               end else if (MEM_ACK) begin
                  mem_req_q <= 1'b0;
                  wait_n_q  <= 1'b1;
                  state_q   <= (drop_q || (CE_R && CS_N)) ? ST_IDLE : ST_DONE;
                  if (!drop_q && !(CE_R && CS_N) && acc_rd_q) begin
                     di_q <= lane_rdata_s;
                  end
               end else if (cnt_q == TO_LAST) begin
                  wait_n_q <= 1'b1;
                  err_q    <= 1'b1;
                  di_q     <= 32'hFFFF_FFFF;
                  orphan_q <= 1'b1;
                  state_q  <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign DI      = di_q;
   assign WAIT_N  = wait_n_q;
   assign MEM_A   = mem_a_q;
   assign MEM_DO  = mem_do_q;
   assign MEM_BE  = mem_be_q;
   assign MEM_WE  = mem_we_q;
   assign MEM_REQ = mem_req_q;
   assign ERR     = err_q;

endmodule

// File: tb/tb_sh_ext_slave.sv
// Bench for sh_ext_slave: 8/16/32-bit instances driven in lockstep, checked
// against table constants and a lane model derived from the addressing rules.
module tb_sh_ext_slave;

   logic        CLK, RST_N, CE_R, CE_F, BS_N, CS_N, RD_WR_N, RD_N, MEM_ACK;
   logic [26:0] A;
   logic [31:0] DO, MEM_DI;
   logic [3:0]  WE_N;

   logic [2:0]       wait_w, req_w, we_w, err_w;
   logic [2:0][3:0]  be_w;
   logic [2:0][31:0] di_w, mdo_w;
   logic [2:0][26:0] ma_w;

   int checks = 0;
   int errors = 0;
   logic [2:0][31:0] last_di;
   logic [2:0][3:0]  bc;
   logic [2:0][31:0] dc, ic;

   typedef struct {
      int          psz;
      logic [26:0] a;
      logic        rd;
      logic [31:0] d;
      logic [3:0]  wen;
      logic [31:0] mdi;
      int          dly;
      bit          rel;
      logic [3:0]  xbe;
      logic [31:0] xdo;
      logic [31:0] xdi;
   } vec_t;

   vec_t tv[7];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sh_ext_slave #(.CS_NUM(0), .PORT_SZ(2'(g + 1)), .TIMEOUT(8)) u_dut (
         .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .A(A), .DO(DO),
         .DI(di_w[g]), .BS_N(BS_N), .CS_N(CS_N), .RD_WR_N(RD_WR_N), .RD_N(RD_N),
         .WE_N(WE_N), .WAIT_N(wait_w[g]), .MEM_A(ma_w[g]), .MEM_DO(mdo_w[g]),
         .MEM_BE(be_w[g]), .MEM_WE(we_w[g]), .MEM_REQ(req_w[g]), .MEM_DI(MEM_DI),
         .MEM_ACK(MEM_ACK), .ERR(err_w[g])
      );
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] m_be(input int psz, input logic [26:0] a, input logic rd, input logic [3:0] wen);
      logic [3:0] en;
      int lane;
      en = rd ? 4'hF : ~wen;
      case (psz)
         1: begin
            lane = 3 - int'(a[1:0]);
            return en[0] ? 4'(1 << lane) : 4'h0;
         end
         2: begin
            lane = a[1] ? 0 : 2;
            return 4'({2'b00, en[1:0]} << lane);
         end
         default: return en;
      endcase
   endfunction

   function automatic logic [31:0] m_do(input int psz, input logic [31:0] d);
      case (psz)
         1: return 32'h01010101 * {24'h0, d[7:0]};
         2: return 32'h00010001 * {16'h0, d[15:0]};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] m_di(input int psz, input logic [26:0] a, input logic [31:0] mdi);
      case (psz)
         1: return (mdi >> (8 * (3 - int'(a[1:0])))) & 32'h0000_00FF;
         2: return a[1] ? (mdi & 32'h0000_FFFF) : (mdi >> 16);
         default: return mdi;
      endcase
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " wait_n"}, wait_w, 3'b111);
      chk({tag, " mem_req"}, req_w, 3'b000);
      chk({tag, " mem_we"}, we_w, 3'b000);
      chk({tag, " err"}, err_w, 3'b000);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("%s di psz%0d", tag, g + 1), di_w[g], 32'h0);
         chk($sformatf("%s mem_a psz%0d", tag, g + 1), ma_w[g], 32'h0);
         chk($sformatf("%s mem_do psz%0d", tag, g + 1), mdo_w[g], 32'h0);
         chk($sformatf("%s mem_be psz%0d", tag, g + 1), be_w[g], 32'h0);
      end
   endtask

   task automatic access(input logic [26:0] a, input logic rd, input logic [31:0] d,
                         input logic [3:0] wen, input logic [31:0] mdi, input int dly,
                         input bit rel, output logic [2:0][3:0] be_cap,
                         output logic [2:0][31:0] do_cap, output logic [2:0][31:0] di_cap);
      A = a; RD_WR_N = rd; RD_N = !rd; DO = d; WE_N = wen; BS_N = 1'b0; CS_N = 1'b0;
      tick();
      BS_N = 1'b1;
      be_cap = be_w;
      do_cap = mdo_w;
      chk("start wait_n", wait_w, 3'b000);
      chk("start mem_req", req_w, 3'b111);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("mem_a psz%0d", g + 1), ma_w[g], {a[26:2], 2'b00});
         chk($sformatf("mem_we psz%0d", g + 1), we_w[g], !rd);
         chk($sformatf("mem_be psz%0d", g + 1), be_w[g], m_be(g + 1, a, rd, wen));
         if (!rd) chk($sformatf("mem_do psz%0d", g + 1), mdo_w[g], m_do(g + 1, d));
      end
      for (int i = 0; i < dly; i++) begin
         tick();
         chk("wait_n held", wait_w, 3'b000);
         chk("mem_req held", req_w, 3'b111);
      end
      MEM_ACK = 1'b1; MEM_DI = mdi;
      tick();
      MEM_ACK = 1'b0; MEM_DI = $urandom;
      di_cap = di_w;
      chk("ack wait_n", wait_w, 3'b111);
      chk("ack mem_req", req_w, 3'b000);
      chk("ack err", err_w, 3'b000);
      if (rd) begin
         for (int g = 0; g < 3; g++) begin
            last_di[g] = m_di(g + 1, a, mdi);
            chk($sformatf("di psz%0d", g + 1), di_w[g], last_di[g]);
         end
      end
      if (rel) begin
         CS_N = 1'b1;
         tick();
      end
   endtask

   initial begin
      int n, ep, p;
      bit found;
      tv[0] = '{3, 27'h0000104, 1'b1, 32'h0, 4'hF, 32'h11223344, 3, 1'b1, 4'hF, 32'h0, 32'h11223344};
      tv[1] = '{1, 27'h0000102, 1'b0, 32'h5A, 4'hE, 32'h0, 1, 1'b0, 4'h2, 32'h5A5A5A5A, 32'h0};
      tv[2] = '{2, 27'h0000106, 1'b1, 32'h0, 4'hF, 32'hAAAABBBB, 0, 1'b1, 4'h3, 32'h0, 32'h0000BBBB};
      tv[3] = '{3, 27'h0000200, 1'b0, 32'hDEADBEEF, 4'hF, 32'h0, 2, 1'b1, 4'h0, 32'hDEADBEEF, 32'h0};
      tv[4] = '{1, 27'h0000003, 1'b1, 32'h0, 4'hF, 32'h11223344, 1, 1'b0, 4'h1, 32'h0, 32'h00000044};
      tv[5] = '{2, 27'h0000000, 1'b0, 32'h1234, 4'hC, 32'h0, 2, 1'b1, 4'hC, 32'h12341234, 32'h0};
      tv[6] = '{1, 27'h0000000, 1'b1, 32'h0, 4'hF, 32'h11223344, 4, 1'b1, 4'h8, 32'h0, 32'h00000011};

      RST_N = 1'b0; CE_R = 1'b1; CE_F = 1'b0; BS_N = 1'b1; CS_N = 1'b1; RD_WR_N = 1'b1;
      RD_N = 1'b1; MEM_ACK = 1'b0; A = 27'd0; DO = 32'd0; MEM_DI = 32'd0; WE_N = 4'hF;
      last_di = '0;
      tick(); tick();
      chk_reset("reset");
      RST_N = 1'b1;
      tick();
      chk_reset("post-reset idle");

      for (int i = 0; i < 7; i++) begin
         access(tv[i].a, tv[i].rd, tv[i].d, tv[i].wen, tv[i].mdi, tv[i].dly, tv[i].rel, bc, dc, ic);
         p = tv[i].psz - 1;
         chk($sformatf("vec%0d mem_be", i), bc[p], tv[i].xbe);
         if (tv[i].rd) chk($sformatf("vec%0d di", i), ic[p], tv[i].xdi);
         else chk($sformatf("vec%0d mem_do", i), dc[p], tv[i].xdo);
      end

      // Timeout: no acknowledge at all.
      A = 27'h0000040; RD_WR_N = 1'b1; RD_N = 1'b0; BS_N = 1'b0; CS_N = 1'b0;
      tick();
      BS_N = 1'b1;
      n = 0; ep = 0;
      while (wait_w == 3'b000 && n < 20) begin
         tick();
         n++;
         if (err_w == 3'b111) ep++;
      end
      chk("timeout wait cycles", n, 8);
      chk("timeout wait_n", wait_w, 3'b111);
      for (int g = 0; g < 3; g++) begin
         last_di[g] = 32'hFFFF_FFFF;
         chk($sformatf("timeout di psz%0d", g + 1), di_w[g], 32'hFFFF_FFFF);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         if (err_w != 3'b000) ep++;
      end
      chk("timeout err pulses", ep, 1);
      chk("orphan mem_req held", req_w, 3'b111);

      // New start while the timed-out request is still outstanding.
      A = 27'h0000010; RD_WR_N = 1'b1; BS_N = 1'b0;
      tick();
      BS_N = 1'b1;
      chk("delayed start wait_n", wait_w, 3'b000);
      tick(); chk("delayed wait_n", wait_w, 3'b000);
      tick(); chk("delayed wait_n", wait_w, 3'b000);
      MEM_ACK = 1'b1; MEM_DI = 32'hBAD0BAD0;
      tick();
      MEM_ACK = 1'b0;
      chk("stale ack wait_n", wait_w, 3'b000);
      found = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
         if (req_w == 3'b111 && ma_w[0] == 27'h10 && ma_w[2] == 27'h10) found = 1'b1;
         else begin
            tick();
            chk("delayed wait_n", wait_w, 3'b000);
         end
      end
      chk("delayed request issued", found, 1);
      MEM_ACK = 1'b1; MEM_DI = 32'hCAFEF00D;
      tick();
      MEM_ACK = 1'b0;
      chk("delayed ack wait_n", wait_w, 3'b111);
      for (int g = 0; g < 3; g++) begin
         last_di[g] = m_di(g + 1, 27'h10, 32'hCAFEF00D);
         chk($sformatf("delayed di psz%0d", g + 1), di_w[g], last_di[g]);
      end
      CS_N = 1'b1;
      tick();

      // Chip select released mid-request: request held, result dropped.
      A = 27'h0000080; RD_WR_N = 1'b1; BS_N = 1'b0; CS_N = 1'b0;
      tick();
      BS_N = 1'b1; CS_N = 1'b1;
      tick(); chk("cs drop mem_req", req_w, 3'b111);
      tick(); chk("cs drop mem_req", req_w, 3'b111);
      MEM_ACK = 1'b1; MEM_DI = 32'h99999999;
      tick();
      MEM_ACK = 1'b0;
      chk("cs drop ack mem_req", req_w, 3'b000);
      chk("cs drop ack wait_n", wait_w, 3'b111);
      for (int g = 0; g < 3; g++) chk($sformatf("cs drop di psz%0d", g + 1), di_w[g], last_di[g]);

      // Stray acknowledge while idle.
      MEM_ACK = 1'b1; MEM_DI = 32'h77777777;
      tick();
      MEM_ACK = 1'b0;
      tick();
      chk("stray ack mem_req", req_w, 3'b000);
      chk("stray ack wait_n", wait_w, 3'b111);
      for (int g = 0; g < 3; g++) chk($sformatf("stray ack di psz%0d", g + 1), di_w[g], last_di[g]);

      // Start strobe without CE_R is not a start.
      CE_R = 1'b0; BS_N = 1'b0; CS_N = 1'b0;
      tick();
      chk("no ce_r mem_req", req_w, 3'b000);
      chk("no ce_r wait_n", wait_w, 3'b111);
      CE_R = 1'b1; BS_N = 1'b1; CS_N = 1'b1;
      tick();

      for (int i = 0; i < 40; i++) begin
         access(27'($urandom), 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                $urandom, $urandom_range(0, 5), 1'($urandom_range(0, 1)), bc, dc, ic);
      end
      CS_N = 1'b1;
      tick();

      // Reset asserted in the middle of a request.
      A = 27'h0000300; RD_WR_N = 1'b1; BS_N = 1'b0; CS_N = 1'b0;
      tick();
      BS_N = 1'b1; CS_N = 1'b1;
      chk("pre-reset mem_req", req_w, 3'b111);
      #2;
      RST_N = 1'b0;
      #1;
      chk_reset("mid-access reset");
      tick();
      RST_N = 1'b1;
      tick();
      chk_reset("after mid-access reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
